// File: rtl/ch0re_alu_arb_if.sv
// ALU operation encoding and the signal bundle shared by the issue logic,
// the ALU arbiter and the shared combinational ALU.
package ch0re_alu_pkg;
  typedef enum logic [3:0] {
    ALU_EQ   = 4'd0,
    ALU_NE   = 4'd1,
    ALU_LT   = 4'd2,
    ALU_LTU  = 4'd3,
    ALU_ADD  = 4'd4,
    ALU_SUB  = 4'd5,
    ALU_AND  = 4'd6,
    ALU_OR   = 4'd7,
    ALU_XOR  = 4'd8,
    ALU_SLL  = 4'd9,
    ALU_SRL  = 4'd10,
    ALU_SRA  = 4'd11,
    ALU_SLT  = 4'd12,
    ALU_SLTU = 4'd13
  } alu_op_e;
endpackage

interface ch0re_alu_arb_if #(
  parameter int XLEN = 64
);
  import ch0re_alu_pkg::*;

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // ready may depend on valid, valid must never depend on ready, and a raised
  // valid holds its payload steady until the transfer happens.
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  alu_op_e [1:0]         req_op;
  logic [1:0][XLEN-1:0]  req_s1;
  logic [1:0][XLEN-1:0]  req_s2;

  logic [1:0]            rsp_valid;
  logic [1:0]            rsp_ready;
  logic [1:0][XLEN-1:0]  rsp_res;
  logic [1:0]            rsp_flag_zero;
  logic [1:0]            rsp_flag_lt;

  alu_op_e               alu_op;
  logic [XLEN-1:0]       alu_s1;
  logic [XLEN-1:0]       alu_s2;
  logic [XLEN-1:0]       alu_res;
  logic                  alu_flag_zero;
  logic                  alu_flag_lt;

  modport master (
    output req_valid, req_op, req_s1, req_s2, rsp_ready,
           alu_res, alu_flag_zero, alu_flag_lt,
    input  req_ready, rsp_valid, rsp_res, rsp_flag_zero, rsp_flag_lt,
           alu_op, alu_s1, alu_s2
  );

  modport slave (
    input  req_valid, req_op, req_s1, req_s2, rsp_ready,
           alu_res, alu_flag_zero, alu_flag_lt,
    output req_ready, rsp_valid, rsp_res, rsp_flag_zero, rsp_flag_lt,
           alu_op, alu_s1, alu_s2
  );
endinterface

// File: rtl/ch0re_alu_arb.sv
// Round-robin sharing of one combinational ALU between two requesters, with a
// registered response slot per requester.
module ch0re_alu_arb
  import ch0re_alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input logic            clk,
  input logic            rst,
  ch0re_alu_arb_if.slave bus
);

  logic [1:0]           rsp_valid_q;
  logic [1:0][XLEN-1:0] rsp_res_q;
  logic [1:0]           rsp_zero_q;
  logic [1:0]           rsp_lt_q;
  logic                 last_gnt_q;

  logic [1:0]           slot_free;
  logic [1:0]           elig;
  logic [1:0]           grant;
  logic                 gnt_idx;

  // A slot can take a new result when empty or when it is drained this cycle.
  assign slot_free = ~rsp_valid_q | bus.rsp_ready;
  assign elig      = bus.req_valid & slot_free;

  always_comb begin
    grant = 2'b00;
    if (!rst) begin
      case (elig)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_gnt_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign gnt_idx       = grant[1];
  assign bus.req_ready = grant;

  // Idle cycles present ADD 0,0 so the ALU inputs stay quiet.
  always_comb begin
    bus.alu_op = ALU_ADD;
    bus.alu_s1 = '0;
    bus.alu_s2 = '0;
    if (|grant) begin
      bus.alu_op = bus.req_op[gnt_idx];
      bus.alu_s1 = bus.req_s1[gnt_idx];
      bus.alu_s2 = bus.req_s2[gnt_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 2'b00;
      rsp_res_q   <= '0;
      rsp_zero_q  <= 2'b00;
      rsp_lt_q    <= 2'b00;
      last_gnt_q  <= 1'b1;
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (grant[r]) begin
          rsp_valid_q[r] <= 1'b1;
          rsp_res_q[r]   <= bus.alu_res;
          rsp_zero_q[r]  <= bus.alu_flag_zero;
          rsp_lt_q[r]    <= bus.alu_flag_lt;
        end else if (bus.rsp_ready[r]) begin
          rsp_valid_q[r] <= 1'b0;
        end
      end
      if (|grant) begin
        last_gnt_q <= gnt_idx;
      end
    end
  end

  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_res       = rsp_res_q;
  assign bus.rsp_flag_zero = rsp_zero_q;
  assign bus.rsp_flag_lt   = rsp_lt_q;

endmodule
